// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [1:0]  PCSRC_NONE   = 2'b00;
    localparam logic [1:0]  PCSRC_TARGET = 2'b01;
    localparam logic [1:0]  PCSRC_ALU    = 2'b10;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Fetch/Decode pipeline register: load enable plus synchronous clear to a NOP bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);
    import riscv_pkg::*;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pcplus4;
    logic        r_valid;

    // Clear wins over load so a flush can never be overridden by a fetch.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_instr   <= NOP_INSTR;
            r_pc      <= 32'h0;
            r_pcplus4 <= 32'h0;
            r_valid   <= 1'b0;
        end else if (i_en) begin
            r_instr   <= i_instr;
            r_pc      <= i_pc;
            r_pcplus4 <= i_pc + 32'd4;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pc      = r_pc;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, hold buffer and Decode register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcB,
    input  logic [31:0] PCTargetB,
    input  logic [31:0] ALUResultB,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    import riscv_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pcf;
    logic [31:0]  w_pcf_nxt;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;

    logic         w_redirect;
    logic [31:0]  w_redirect_pc;
    logic         w_load;
    logic         w_capture;
    logic         w_d_clr;
    logic [31:0]  w_d_instr;
    logic [31:0]  w_d_pc;

    assign w_redirect    = (PCSrcB & (PCSRC_TARGET | PCSRC_ALU)) != PCSRC_NONE;
    assign w_redirect_pc = align_pc(((PCSrcB & PCSRC_ALU) != PCSRC_NONE) ? ALUResultB : PCTargetB);

    assign imem_req  = (r_state == S_REQ) && !w_redirect;
    assign imem_addr = r_pcf;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_d_instr   = imem_rdata;
        w_d_pc      = r_pcf;

        unique case (r_state)
            S_REQ: begin
                if (!w_redirect && imem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_redirect) begin
                    w_state_nxt = imem_rvalid ? S_REQ : S_KILL;
                end else if (imem_rvalid) begin
                    // A flushed response is simply refetched from the unchanged PCF.
                    if (FlushD) begin
                        w_state_nxt = S_REQ;
                    end else if (StallD) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_KILL: begin
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (w_redirect || FlushD) begin
                    w_state_nxt = S_REQ;
                end else if (!StallD) begin
                    w_load      = 1'b1;
                    w_d_instr   = r_hold_instr;
                    w_d_pc      = r_hold_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        if (w_redirect)  w_pcf_nxt = w_redirect_pc;
        else if (w_load) w_pcf_nxt = r_pcf + 32'd4;
        else             w_pcf_nxt = r_pcf;

        // Without a stall, a cycle that delivers nothing leaves a bubble in Decode.
        w_d_clr = w_redirect || FlushD || (!StallD && !w_load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pcf   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pcf   <= w_pcf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_hold_instr <= imem_rdata;
            r_hold_pc    <= r_pcf;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_load),
        .i_clr     (w_d_clr),
        .i_instr   (w_d_instr),
        .i_pc      (w_d_pc),
        .o_instr   (InstrD),
        .o_pc      (PCD),
        .o_pcplus4 (PCPlus4D),
        .o_valid   (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: default instance plus a wrap-around RESET_PC instance.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD, FlushD;
    logic [1:0]  PCSrcB;
    logic [31:0] PCTargetB, ALUResultB;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req, ValidD;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
    logic        w2_req, w2_ValidD;
    logic [31:0] w2_addr, w2_InstrD, w2_PCD, w2_PCPlus4D;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } d_exp_t;

    d_exp_t      sb[$];
    logic [31:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .PCSrcB(PCSrcB), .PCTargetB(PCTargetB), .ALUResultB(ALUResultB),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .PCSrcB(PCSrcB), .PCTargetB(PCTargetB), .ALUResultB(ALUResultB),
        .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(w2_InstrD), .PCD(w2_PCD), .PCPlus4D(w2_PCPlus4D), .ValidD(w2_ValidD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        StallD = 1'b0; FlushD = 1'b0; PCSrcB = 2'b00;
        PCTargetB = 32'h0; ALUResultB = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    endtask

    // Grant at the current PC, respond after lat cycles, and record what Decode must show.
    task automatic drive_fetch(input logic [31:0] instr, input int lat);
        d_exp_t e;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        repeat (lat - 1) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        e.instr = instr;
        e.pc    = exp_pc;
        e.pcp4  = exp_pc + 32'd4;
        sb.push_back(e);
        tick();
        imem_rvalid = 1'b0;
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_pc = 32'h0;
        settle();
        checks++;
        if ({InstrD, PCD, PCPlus4D, ValidD} !== {NOP, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_d got %h/%h/%h/%b exp %h/0/0/0", InstrD, PCD, PCPlus4D, ValidD, NOP);
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        settle();
        checks++;
        if ({ValidD, InstrD, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL stray_rvalid got v=%b i=%h req=%b addr=%h exp v=0 i=%h req=1 addr=0",
                     ValidD, InstrD, imem_req, imem_addr, NOP);
        end
    endtask

    task automatic test_basic_fetch();
        d_exp_t e;
        drive_fetch(32'h0050_0093, 1);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL basic_d got empty scoreboard exp one entry");
        end else begin
            e = sb.pop_front();
            if ({InstrD, PCD, PCPlus4D, ValidD} !== {e.instr, e.pc, e.pcp4, 1'b1}) begin
                errors++;
                $display("FAIL basic_d got %h/%h/%h/%b exp %h/%h/%h/1",
                         InstrD, PCD, PCPlus4D, ValidD, e.instr, e.pc, e.pcp4);
            end
        end
        settle();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL basic_next got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        d_exp_t e;
        drive_fetch(32'h0010_0193, 1);
        if (sb.size() != 0) void'(sb.pop_front());
        StallD   = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0113;
        e.instr = 32'h00A0_0113; e.pc = 32'h8; e.pcp4 = 32'hC;
        sb.push_back(e);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_req[%0d] got %b exp 0", i, imem_req);
            end
            tick();
            imem_rvalid = 1'b0;
            checks++;
            if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h0010_0193, 32'h4, 32'h8, 1'b1}) begin
                errors++;
                $display("FAIL stall_d[%0d] got %h/%h/%h/%b exp 00100193/4/8/1",
                         i, InstrD, PCD, PCPlus4D, ValidD);
            end
        end
        StallD = 1'b0;
        tick();
        exp_pc = 32'hC;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL stall_release got empty scoreboard exp one entry");
        end else begin
            e = sb.pop_front();
            if ({InstrD, PCD, PCPlus4D, ValidD} !== {e.instr, e.pc, e.pcp4, 1'b1}) begin
                errors++;
                $display("FAIL stall_release got %h/%h/%h/%b exp %h/%h/%h/1",
                         InstrD, PCD, PCPlus4D, ValidD, e.instr, e.pc, e.pcp4);
            end
        end
        settle();
        checks++;
        if (imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL stall_next got addr=%h exp 0000000c", imem_addr);
        end
    endtask

    task automatic test_redirect_kill();
        drive_fetch(32'h0020_8233, 1);
        if (sb.size() != 0) void'(sb.pop_front());
        StallD   = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt  = 1'b0;
        PCSrcB    = 2'b01;
        PCTargetB = 32'h40;
        settle();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_req got %b exp 0", imem_req);
        end
        tick();
        PCSrcB = 2'b00;
        StallD = 1'b0;
        checks++;
        if ({ValidD, InstrD} !== {1'b0, NOP}) begin
            errors++;
            $display("FAIL redirect_over_stall got v=%b i=%h exp v=0 i=%h", ValidD, InstrD, NOP);
        end
        settle();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL kill_req got %b exp 0", imem_req);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        exp_pc = 32'h40;
        settle();
        checks++;
        if ({ValidD, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40} || sb.size() != 0) begin
            errors++;
            $display("FAIL kill_drop got v=%b req=%b addr=%h exp v=0 req=1 addr=00000040",
                     ValidD, imem_req, imem_addr);
        end
    endtask

    task automatic test_jalr();
        d_exp_t e;
        PCSrcB     = 2'b11;
        ALUResultB = 32'h0000_0103;
        PCTargetB  = 32'h0000_0200;
        settle();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL jalr_req got %b exp 0", imem_req);
        end
        tick();
        PCSrcB = 2'b00;
        exp_pc = 32'h100;
        settle();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL jalr_pc got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr);
        end
        drive_fetch(32'h0000_0033, 2);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL jalr_d got empty scoreboard exp one entry");
        end else begin
            e = sb.pop_front();
            if ({InstrD, PCD, PCPlus4D, ValidD} !== {e.instr, e.pc, e.pcp4, 1'b1}) begin
                errors++;
                $display("FAIL jalr_d got %h/%h/%h/%b exp %h/%h/%h/1",
                         InstrD, PCD, PCPlus4D, ValidD, e.instr, e.pc, e.pcp4);
            end
        end
    endtask

    task automatic test_flush_response();
        d_exp_t e;
        PCSrcB    = 2'b01;
        PCTargetB = 32'h20;
        tick();
        PCSrcB   = 2'b00;
        exp_pc   = 32'h20;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0FF0_0293;
        FlushD      = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        FlushD      = 1'b0;
        settle();
        checks++;
        if ({ValidD, InstrD, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h20}) begin
            errors++;
            $display("FAIL flush_resp got v=%b i=%h req=%b addr=%h exp v=0 i=%h req=1 addr=00000020",
                     ValidD, InstrD, imem_req, imem_addr, NOP);
        end
        drive_fetch(32'h0FF0_0293, 1);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL flush_refetch got empty scoreboard exp one entry");
        end else begin
            e = sb.pop_front();
            if ({InstrD, PCD, PCPlus4D, ValidD} !== {e.instr, e.pc, e.pcp4, 1'b1}) begin
                errors++;
                $display("FAIL flush_refetch got %h/%h/%h/%b exp %h/%h/%h/1",
                         InstrD, PCD, PCPlus4D, ValidD, e.instr, e.pc, e.pcp4);
            end
        end
    endtask

    task automatic test_flush_hold();
        StallD   = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0040_0313;
        tick();
        imem_rvalid = 1'b0;
        FlushD      = 1'b1;
        tick();
        FlushD = 1'b0;
        StallD = 1'b0;
        settle();
        checks++;
        if ({ValidD, InstrD, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, exp_pc}) begin
            errors++;
            $display("FAIL flush_hold got v=%b i=%h req=%b addr=%h exp v=0 i=%h req=1 addr=%h",
                     ValidD, InstrD, imem_req, imem_addr, NOP, exp_pc);
        end
    endtask

    task automatic test_back_to_back();
        d_exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive_fetch($urandom, 1 + (i % 3));
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b[%0d] got empty scoreboard exp one entry", i);
            end else begin
                e = sb.pop_front();
                if ({InstrD, PCD, PCPlus4D, ValidD} !== {e.instr, e.pc, e.pcp4, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b[%0d] got %h/%h/%h/%b exp %h/%h/%h/1",
                             i, InstrD, PCD, PCPlus4D, ValidD, e.instr, e.pc, e.pcp4);
                end
            end
        end
    endtask

    task automatic test_wrap();
        d_exp_t e;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        settle();
        checks++;
        if ({w2_req, w2_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first got req=%b addr=%h exp req=1 addr=fffffffc", w2_req, w2_addr);
        end
        drive_fetch(32'h0050_0093, 1);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL wrap_d got empty scoreboard exp one entry");
        end else begin
            e = sb.pop_front();
            if ({w2_InstrD, w2_PCD, w2_PCPlus4D, w2_ValidD} !== {e.instr, e.pc, e.pcp4, 1'b1}) begin
                errors++;
                $display("FAIL wrap_d got %h/%h/%h/%b exp %h/%h/%h/1",
                         w2_InstrD, w2_PCD, w2_PCPlus4D, w2_ValidD, e.instr, e.pc, e.pcp4);
            end
        end
        settle();
        checks++;
        if (w2_addr !== exp_pc || exp_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next got addr=%h exp 00000000", w2_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_redirect_kill();
        test_jalr();
        test_flush_response();
        test_flush_hold();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction presented in Decode when flushed or empty.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: StallD  in  1  hold the Decode register this cycle.
REQ-006 Port: FlushD  in  1  clear the Decode register this cycle.
REQ-007 Port: PCSrcB  in  2  branch-stage redirect: 00 none, 01 PCTargetB, 1x ALUResultB (jalr).
REQ-008 Port: PCTargetB  in  32  branch/jal target.
REQ-009 Port: ALUResultB  in  32  jalr target.
REQ-010 Port: imem_req  out  1  fetch request valid.
REQ-011 Port: imem_addr  out  32  fetch address, equal to PCF.
REQ-012 Port: imem_gnt  in  1  request accepted this cycle.
REQ-013 Port: imem_rvalid  in  1  response valid; at most one request outstanding.
REQ-014 Port: imem_rdata  in  32  response instruction.
REQ-015 Port: InstrD, PCD, PCPlus4D  out  32 each  Decode-stage instruction, PC, PC+4.
REQ-016 Port: ValidD  out  1  Decode holds a real instruction.

Function
REQ-017 FSM states SHALL be REQ, WAIT, KILL and HOLD.
REQ-018 REQ: imem_req = ~redirect; imem_gnt with imem_req set -> WAIT.
REQ-019 WAIT + rvalid + ~StallD -> load D (InstrD=rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1), PCF+=4 -> REQ.
REQ-020 WAIT + rvalid + StallD -> capture rdata/PCF into a one-entry hold buffer -> HOLD; the D register is unchanged.
REQ-021 WAIT + redirect and no rvalid -> KILL; the response that later arrives SHALL be discarded, then -> REQ.
REQ-022 HOLD + ~StallD -> move the buffer into D, PCF+=4 -> REQ.
REQ-023 redirect = (PCSrcB != 00); on redirect PCF <= (PCSrcB[1] ? ALUResultB : PCTargetB) & ~32'h3.
REQ-024 Redirect priority: redirect over FlushD over StallD.
REQ-025 Redirect effect: D loads NOP_INSTR with ValidD=0; any response in that cycle and any hold buffer are dropped.
REQ-026 Redirect state transitions: REQ/HOLD -> REQ; WAIT without rvalid -> KILL; WAIT with rvalid -> REQ; KILL stays KILL until rvalid.
REQ-027 FlushD without redirect: D loads NOP_INSTR with ValidD=0, even if StallD is set.
REQ-028 FlushD without redirect, at a concurrent WAIT response or in HOLD: the instruction is dropped, PCF is not advanced, and the state goes to REQ so the same PCF is refetched.
REQ-029 StallD alone SHALL hold InstrD/PCD/PCPlus4D/ValidD unchanged.
REQ-030 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
REQ-031 Fetch-to-D latency: a grant at cycle N with rvalid at N+k places the instruction in D at the edge ending cycle N+k; minimum k=1.

Reset
REQ-032 Reset (synchronous, dominant over all inputs) SHALL set: state=REQ, PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, hold buffer empty.
REQ-033 An imem response arriving in the cycle after reset SHALL be ignored, because state is REQ.
REQ-034 Reset mid-transaction: the outstanding response is the memory's responsibility to cancel, since the memory shares the same reset.

Structure
REQ-035 Package riscv_pkg SHALL hold the fetch_state_t enum, the NOP_INSTR constant and the PCSrc encoding constants.
REQ-036 The D register (enable + synchronous clear to NOP) SHALL be a sub-module named if_id_reg; the FSM, PCF and hold buffer stay in fetch_unit.

Verification
REQ-037 Reset, then gnt at cycle 0 and rvalid at cycle 1 with rdata 32'h00500093 -> InstrD=00500093, PCD=0, PCPlus4D=4, ValidD=1; next imem_addr=4.
REQ-038 Response 32'h00A00113 at PC 8 with StallD high for 3 cycles -> D unchanged and imem_req=0 for 3 cycles; then D=00A00113, PCD=8.
REQ-039 In WAIT at PC 0x10, PCSrcB=01, PCTargetB=0x40, rvalid 2 cycles later -> that response is dropped, ValidD=0, next request address is 0x40.
REQ-040 PCSrcB=11, ALUResultB=0x0000_0103 -> PCF=0x100.
REQ-041 FlushD with a simultaneous response at PC 0x20 -> ValidD=0 and the next request address is 0x20.
REQ-042 RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, PCPlus4D=0, next fetch at 0.
